// File: rtl/debug_dumper.sv
// debug_dumper: UART-commanded snapshot dumper.
//   A UART command on debug_uart_rx_in ('S', 'A', or 'D' followed by '0'+n)
//   pulses debug_start, or freezes one or all data_in channels and streams
//   them MSB-byte-first on tx_out, followed by a 0x0A terminator.
// Ports:
//   clk_in           - single clock
//   reset            - asynchronous, active-low reset
//   data_in          - CHANNELS x DATA_WIDTH monitored data, channel n at [n*DATA_WIDTH +: DATA_WIDTH]
//   debug_uart_rx_in - 8N1 command input, idle high
//   tx_out           - 8N1 dump output, idle high
//   debug_start      - one-cycle pulse on the 'S' command
//   busy             - high while a dump is in flight
//   cmd_error        - one-cycle pulse on a framing error or a rejected command
module debug_dumper #(
  parameter int CHANNELS            = 4,
  parameter int DATA_WIDTH          = 24,
  parameter int DIVIDER_TICKS       = 1023,
  parameter int DIVIDER_TICKS_WIDTH = 10
) (
  input  logic                           clk_in,
  input  logic                           reset,
  input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
  input  logic                           debug_uart_rx_in,
  output logic                           tx_out,
  output logic                           debug_start,
  output logic                           busy,
  output logic                           cmd_error
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam logic [DIVIDER_TICKS_WIDTH-1:0] BIT_LAST  = DIVIDER_TICKS_WIDTH'(DIVIDER_TICKS - 1);
  localparam logic [DIVIDER_TICKS_WIDTH-1:0] HALF_LAST = DIVIDER_TICKS_WIDTH'(DIVIDER_TICKS / 2 - 1);
  localparam logic [7:0] BYTE_LAST = 8'(NBYTES - 1);
  localparam logic [3:0] CH_LAST   = 4'(CHANNELS - 1);
  localparam logic [3:0] CH_NUM    = 4'(CHANNELS);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;
  typedef enum logic {P_IDLE, P_CHAN} p_state_e;
  typedef enum logic [2:0] {T_IDLE, T_LOAD, T_START, T_DATA, T_STOP} tx_state_e;

  logic rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
  rx_state_e rx_state_q, rx_state_d;
  logic [DIVIDER_TICKS_WIDTH-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic rx_valid_q, rx_valid_d;

  p_state_e p_state_q, p_state_d;
  logic debug_start_q, debug_start_d, cmd_error_q, cmd_error_d;

  tx_state_e tx_state_q, tx_state_d;
  logic [DIVIDER_TICKS_WIDTH-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic tx_q, tx_d, busy_q, busy_d;
  logic [CHANNELS*DATA_WIDTH-1:0] snap_q, snap_d;
  logic [3:0] ch_q, ch_d, last_ch_q, last_ch_d;
  logic [7:0] bi_q, bi_d;
  logic term_q, term_d;
  logic [3:0] next_ch;
  logic [7:0] next_bi;
  logic next_term;

  // Byte bi (0 = most significant) of snapshot slot ch.
  function automatic logic [7:0] pick_byte(input logic [CHANNELS*DATA_WIDTH-1:0] s,
                                           input logic [3:0] ch, input logic [7:0] bi);
    logic [7:0] r;
    r = '0;
    for (int unsigned c = 0; c < CHANNELS; c++)
      for (int unsigned k = 0; k < NBYTES; k++)
        if (4'(c) == ch && 8'(k) == bi)
          r = s[c*DATA_WIDTH + (NBYTES-1-k)*8 +: 8];
    return r;
  endfunction

  always_comb begin
    rx_s1_d    = debug_uart_rx_in;
    rx_s2_d    = rx_s1_q;
    rx_prev_d  = rx_s2_q;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = 1'b0;
    p_state_d     = p_state_q;
    debug_start_d = 1'b0;
    cmd_error_d   = 1'b0;
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    snap_d     = snap_q;
    ch_d       = ch_q;
    last_ch_d  = last_ch_q;
    bi_d       = bi_q;
    term_d     = term_q;
    next_ch    = ch_q;
    next_bi    = bi_q;
    next_term  = term_q;

    // Receiver
    unique case (rx_state_q)
      R_IDLE: if (rx_prev_q && !rx_s2_q) begin
        rx_state_d = R_START;
        rx_cnt_d   = '0;
      end
      R_START: if (rx_cnt_q == HALF_LAST) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s2_q ? R_IDLE : R_DATA;
      end else rx_cnt_d = rx_cnt_q + 1'b1;
      R_DATA: if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
        rx_bit_d   = rx_bit_q + 1'b1;
        if (rx_bit_q == 3'd7) rx_state_d = R_STOP;
      end else rx_cnt_d = rx_cnt_q + 1'b1;
      R_STOP: if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d    = '0;
        rx_state_d  = R_IDLE;
        rx_valid_d  = rx_s2_q;
        cmd_error_d = !rx_s2_q;
      end else rx_cnt_d = rx_cnt_q + 1'b1;
      default: rx_state_d = R_IDLE;
    endcase

    // Transmitter; stop-bit end chains straight into the next start bit
    unique case (tx_state_q)
      T_IDLE: tx_d = 1'b1;
      T_LOAD: begin
        ch_d       = '0;
        bi_d       = '0;
        term_d     = 1'b0;
        tx_shift_d = pick_byte(snap_q, 4'd0, 8'd0);
        tx_d       = 1'b0;
        tx_cnt_d   = '0;
        tx_state_d = T_START;
      end
      T_START: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_d       = tx_shift_q[0];
        tx_state_d = T_DATA;
      end else tx_cnt_d = tx_cnt_q + 1'b1;
      T_DATA: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 3'd7) begin
          tx_d       = 1'b1;
          tx_state_d = T_STOP;
        end else begin
          tx_bit_d   = tx_bit_q + 1'b1;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_d       = tx_shift_q[1];
        end
      end else tx_cnt_d = tx_cnt_q + 1'b1;
      T_STOP: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d = '0;
        if (term_q) begin
          tx_state_d = T_IDLE;
          busy_d     = 1'b0;
          tx_d       = 1'b1;
        end else begin
          if (bi_q == BYTE_LAST) begin
            next_bi = '0;
            if (ch_q == last_ch_q) next_term = 1'b1;
            else next_ch = ch_q + 1'b1;
          end else next_bi = bi_q + 1'b1;
          ch_d       = next_ch;
          bi_d       = next_bi;
          term_d     = next_term;
          tx_shift_d = next_term ? 8'h0A : pick_byte(snap_q, next_ch, next_bi);
          tx_d       = 1'b0;
          tx_state_d = T_START;
        end
      end else tx_cnt_d = tx_cnt_q + 1'b1;
      default: tx_state_d = T_IDLE;
    endcase

    // Command parser; a dump only starts while TX is idle (busy low)
    if (rx_valid_q) begin
      unique case (p_state_q)
        P_IDLE: begin
          if (rx_shift_q == 8'h53) debug_start_d = 1'b1;
          else if (rx_shift_q == 8'h44) p_state_d = P_CHAN;
          else if (rx_shift_q == 8'h41 && !busy_q) begin
            snap_d     = data_in;
            last_ch_d  = CH_LAST;
            busy_d     = 1'b1;
            tx_state_d = T_LOAD;
          end else cmd_error_d = 1'b1;
        end
        P_CHAN: begin
          p_state_d = P_IDLE;
          if (rx_shift_q[7:4] == 4'h3 && rx_shift_q[3:0] < CH_NUM && !busy_q) begin
            // Single-channel dumps always use snapshot slot 0.
            snap_d = '0;
            for (int unsigned c = 0; c < CHANNELS; c++)
              if (4'(c) == rx_shift_q[3:0])
                snap_d[DATA_WIDTH-1:0] = data_in[c*DATA_WIDTH +: DATA_WIDTH];
            last_ch_d  = '0;
            busy_d     = 1'b1;
            tx_state_d = T_LOAD;
          end else cmd_error_d = 1'b1;
        end
        default: p_state_d = P_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      rx_s1_q       <= 1'b1;
      rx_s2_q       <= 1'b1;
      rx_prev_q     <= 1'b1;
      rx_state_q    <= R_IDLE;
      rx_cnt_q      <= '0;
      rx_bit_q      <= '0;
      rx_shift_q    <= '0;
      rx_valid_q    <= 1'b0;
      p_state_q     <= P_IDLE;
      debug_start_q <= 1'b0;
      cmd_error_q   <= 1'b0;
      tx_state_q    <= T_IDLE;
      tx_cnt_q      <= '0;
      tx_bit_q      <= '0;
      tx_shift_q    <= '0;
      tx_q          <= 1'b1;
      busy_q        <= 1'b0;
      snap_q        <= '0;
      ch_q          <= '0;
      last_ch_q     <= '0;
      bi_q          <= '0;
      term_q        <= 1'b0;
    end else begin
      rx_s1_q       <= rx_s1_d;
      rx_s2_q       <= rx_s2_d;
      rx_prev_q     <= rx_prev_d;
      rx_state_q    <= rx_state_d;
      rx_cnt_q      <= rx_cnt_d;
      rx_bit_q      <= rx_bit_d;
      rx_shift_q    <= rx_shift_d;
      rx_valid_q    <= rx_valid_d;
      p_state_q     <= p_state_d;
      debug_start_q <= debug_start_d;
      cmd_error_q   <= cmd_error_d;
      tx_state_q    <= tx_state_d;
      tx_cnt_q      <= tx_cnt_d;
      tx_bit_q      <= tx_bit_d;
      tx_shift_q    <= tx_shift_d;
      tx_q          <= tx_d;
      busy_q        <= busy_d;
      snap_q        <= snap_d;
      ch_q          <= ch_d;
      last_ch_q     <= last_ch_d;
      bi_q          <= bi_d;
      term_q        <= term_d;
    end
  end

  assign tx_out      = tx_q;
  assign debug_start = debug_start_q;
  assign busy        = busy_q;
  assign cmd_error   = cmd_error_q;

endmodule

// File: doc/debug_dumper.md
DEBUG_DUMPER -- requirements
Module: debug_dumper

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of monitored data channels, 1..10.
REQ-002 SHALL have parameter DATA_WIDTH, default 24: bits per channel, a multiple of 8.
REQ-003 SHALL have parameter DIVIDER_TICKS, default 1023: clk_in cycles per UART bit, at least 4.
REQ-004 SHALL have parameter DIVIDER_TICKS_WIDTH, default 10: bit counter width, enough to hold DIVIDER_TICKS.
REQ-005 SHALL have port clk_in, input, 1 bit: the single clock.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port data_in, input, CHANNELS*DATA_WIDTH bits: channel n occupies bits [n*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port debug_uart_rx_in, input, 1 bit: UART command line, 8N1, idle high.
REQ-009 SHALL have port tx_out, output, 1 bit: UART dump line, 8N1, idle high.
REQ-010 SHALL have port debug_start, output, 1 bit: one-cycle pulse when the start command is received.
REQ-011 SHALL have port busy, output, 1 bit: high while a dump is being transmitted.
REQ-012 SHALL have port cmd_error, output, 1 bit: one-cycle pulse on a framing error or a rejected command.

Function
REQ-013 SHALL pass debug_uart_rx_in through a 2-flop synchronizer before any use.
REQ-014 RX SHALL detect start on the synchronized high-to-low edge, then wait DIVIDER_TICKS/2 cycles and resample.
- If the resampled line is high: false start, return to RX idle with no error.
REQ-015 RX SHALL then sample 8 data bits, LSB first, followed by the stop bit, each DIVIDER_TICKS cycles apart.
REQ-016 A stop bit sampled low SHALL discard the byte and pulse cmd_error in the cycle after the stop sample.
REQ-017 A valid byte SHALL be presented to the parser in the cycle after the stop sample (rx_valid).
REQ-018 Parser states SHALL be P_IDLE and P_CHAN.
REQ-019 In P_IDLE, byte 0x53 'S' SHALL pulse debug_start in the cycle after rx_valid, regardless of busy.
REQ-020 In P_IDLE, byte 0x44 'D' SHALL move the parser to P_CHAN.
REQ-021 In P_IDLE, byte 0x41 'A' SHALL snapshot all channels in one cycle and start a dump of channels 0..CHANNELS-1 in ascending order.
REQ-022 In P_IDLE, any other byte SHALL pulse cmd_error and leave the parser in P_IDLE.
REQ-023 In P_CHAN, a byte 0x30+n with n<CHANNELS SHALL snapshot channel n only and start a single-channel dump; the parser SHALL return to P_IDLE.
REQ-024 In P_CHAN, any other byte SHALL pulse cmd_error and return the parser to P_IDLE.
REQ-025 A 'D'+channel or 'A' command completing while busy=1 SHALL be rejected with a cmd_error pulse; the dump in progress SHALL continue unaffected.
REQ-026 The snapshot SHALL be taken in the cycle after rx_valid; later changes to data_in SHALL NOT affect the dump.
REQ-027 TX states SHALL be T_IDLE, T_LOAD, T_START, T_DATA and T_STOP.
REQ-028 busy SHALL rise in the snapshot cycle and tx_out SHALL drop to the start bit in the following cycle.
REQ-029 Each channel SHALL be sent as DATA_WIDTH/8 bytes, most-significant byte first, each byte LSB first.
REQ-030 Each bit SHALL be held for exactly DIVIDER_TICKS cycles, with one stop bit and no idle gap between bytes.
REQ-031 After the last channel byte, terminator byte 0x0A SHALL be sent.
REQ-032 busy SHALL fall in the cycle after the terminator's stop bit ends.
REQ-033 RX and TX SHALL run concurrently and independently.

Reset
REQ-034 While reset=0, all of the following SHALL hold immediately and asynchronously:
- tx_out=1; debug_start=0; busy=0; cmd_error=0.
- Parser in P_IDLE; TX in T_IDLE; RX in idle; bit counters and snapshot cleared.
REQ-035 A reset asserted mid-byte SHALL abort the byte; after reset is released, no partial frame or command SHALL resume.

Verification (CHANNELS=4, DATA_WIDTH=24, DIVIDER_TICKS=16)
REQ-036 Send 'S' -> debug_start high for exactly 1 cycle; busy stays 0; tx_out stays 1.
REQ-037 Set channel 2 = 0xF0AA0D, send 'D','2' -> tx_out carries bytes F0, AA, 0D, 0A at 16 cycles per bit; busy spans the whole dump.
REQ-038 Send 'D','7' and then 'Q' -> one cmd_error pulse per command; no transmission.
REQ-039 Send 'A' with channels 0x000001, 0x000002, 0x000003, 0x000004, change data_in during the dump -> 13 bytes received, matching the snapshot values.
REQ-040 Send a frame with stop bit=0, then 'S' -> cmd_error pulse on the bad frame; debug_start pulse on 'S'.
REQ-041 Assert reset during the second byte of a dump -> tx_out=1 and busy=0 immediately; after release, a new 'D','0' dumps correctly.
